// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: clock glitch filter, odd-parity/stop checking,
// mid-frame inactivity timeout and a first-word-fall-through output FIFO.
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   rx_clk, rx       PS/2 clock and data pins (asynchronous, idle high)
//   data_out         FIFO head byte, valid while data_valid=1
//   data_valid       FIFO not empty
//   data_ready       consumer accepts the head when data_valid & data_ready
//   fifo_count       FIFO occupancy 0..FIFO_DEPTH
//   busy             frame in progress
//   err_parity       pulse: parity failed, byte discarded
//   err_frame        pulse: stop bit was 0, byte discarded
//   err_timeout      pulse: frame aborted by inactivity timeout
//   overflow         pulse: good byte dropped because the FIFO was full
module ps2_rx_buffered #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_clk,
  input  logic                              rx,
  output logic [7:0]                        data_out,
  output logic                              data_valid,
  input  logic                              data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              busy,
  output logic                              err_parity,
  output logic                              err_frame,
  output logic                              err_timeout,
  output logic                              overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1, clk_s2, rx_s1, rx_s2;
  logic          filt, filt_d;
  logic [FW-1:0] fcnt;
  logic          sample_edge;

  state_t        state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_cnt, bit_n;
  logic          par_bit, par_n;
  logic [TW-1:0] to_cnt;
  logic          push_c, perr_c, ferr_c, tout_c;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [7:0]    head_n;
  logic          pop_c, wr_c, ovf_c;

  // Two-flop synchronisers, preset to the idle-high line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
    end else begin
      clk_s1 <= rx_clk;
      clk_s2 <= clk_s1;
      rx_s1  <= rx;
      rx_s2  <= rx_s1;
    end
  end

  // Counter filter: accept a new clock level after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s2 != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt <= clk_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign sample_edge = filt_d & ~filt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Frame sequencing, frame evaluation and timeout abort
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    par_n   = par_bit;
    push_c  = 1'b0;
    perr_c  = 1'b0;
    ferr_c  = 1'b0;
    tout_c  = 1'b0;
    if (sample_edge) begin
      case (state)
        S_IDLE: begin
          if (!rx_s2) begin
            state_n = S_DATA;
            shift_n = '0;
            bit_n   = '0;
            par_n   = 1'b0;
          end
        end
        S_DATA: begin
          shift_n = {rx_s2, shift[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: begin
          par_n   = rx_s2;
          state_n = S_STOP;
        end
        S_STOP: begin
          state_n = S_IDLE;
          // Odd parity: data bits XOR parity bit must be 1; parity error wins over stop error
          if ((^shift ^ par_bit) == 1'b0) perr_c = 1'b1;
          else if (!rx_s2)                ferr_c = 1'b1;
          else                            push_c = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
      state_n = S_IDLE;
      tout_c  = 1'b1;
    end
  end

  // Shift register, bit counter, parity bit, inactivity timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      shift   <= shift_n;
      bit_cnt <= bit_n;
      par_bit <= par_n;
      if (sample_edge || state == S_IDLE || tout_c) to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES))       to_cnt <= to_cnt + TW'(1);
    end
  end

  // FIFO control: a pop in the same cycle frees room for a push into a full FIFO
  always_comb begin
    pop_c    = data_valid & data_ready;
    wr_c     = push_c & ((fifo_count != CW'(FIFO_DEPTH)) | pop_c);
    ovf_c    = push_c & ~wr_c;
    rd_ptr_n = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = fifo_count;
    if (wr_c && !pop_c)      count_n = fifo_count + CW'(1);
    else if (!wr_c && pop_c) count_n = fifo_count - CW'(1);
    // The new head is the byte being written when the read pointer lands on the write slot
    if (wr_c && rd_ptr_n == wr_ptr) head_n = shift;
    else                            head_n = mem[rd_ptr_n];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= shift;
  end

  // FIFO pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rd_ptr      <= rd_ptr_n;
      if (wr_c) wr_ptr <= wr_ptr + AW'(1);
      fifo_count  <= count_n;
      if (count_n != '0) data_out <= head_n;
      data_valid  <= (count_n != '0);
      busy        <= (state_n != S_IDLE);
      err_parity  <= perr_c;
      err_frame   <= ferr_c;
      err_timeout <= tout_c;
      overflow    <= ovf_c;
    end
  end

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Self-checking bench for ps2_rx_buffered: randomized PS/2 bit timing and
// payloads checked against a queue-based model of the delivered byte stream
// and expected error-pulse counts.
module tb_ps2_rx_buffered;

  localparam int unsigned FILTER_LEN     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 2000;
  localparam int unsigned FIFO_DEPTH     = 8;

  logic       clk = 1'b0;
  logic       rst, rx_clk, rx, data_ready;
  logic [7:0] data_out;
  logic       data_valid, busy, err_parity, err_frame, err_timeout, overflow;
  logic [3:0] fifo_count;

  int vectors    = 0;
  int miscompares = 0;

  // Observed pulse counts and model expectations
  int n_perr = 0, n_ferr = 0, n_tout = 0, n_ovf = 0;
  int e_perr = 0, e_ferr = 0, e_tout = 0, e_ovf = 0;
  bit busy_seen = 1'b0;
  logic [7:0] q [$];

  ps2_rx_buffered #(
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rx_clk(rx_clk), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .fifo_count(fifo_count), .busy(busy),
    .err_parity(err_parity), .err_frame(err_frame),
    .err_timeout(err_timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_parity)  n_perr++;
    if (err_frame)   n_ferr++;
    if (err_timeout) n_tout++;
    if (overflow)    n_ovf++;
    if (busy)        busy_seen = 1'b1;
  end

  // One PS/2 bit: data set while clock high, then clock low; optional one-cycle
  // pop aligned with the cycle the receiver evaluates this (stop) bit.
  task automatic ps2_bit(input logic b, input bit pop);
    int hi, lo;
    hi = $urandom_range(6, 12);
    lo = $urandom_range(8, 14);
    rx = b;
    repeat (hi) @(negedge clk);
    rx_clk = 1'b0;
    if (pop) begin
      repeat (6) @(negedge clk);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      repeat (lo - 7) @(negedge clk);
    end else begin
      repeat (lo) @(negedge clk);
    end
    rx_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit pop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], pop && i == 10);
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // Model of one completed frame's effect (no pop during the frame)
  task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    if (bad_par)                  e_perr++;
    else if (bad_stop)            e_ferr++;
    else if (q.size() < FIFO_DEPTH) q.push_back(d);
    else                          e_ovf++;
  endtask

  task automatic test_reset;
    vectors++;
    if ({data_out, data_valid, fifo_count, busy, err_parity, err_frame, err_timeout, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: data_out=%h valid=%b count=%0d busy=%b", data_out, data_valid, fifo_count, busy);
    end
  endtask

  task automatic test_good_frame;
    send_frame(8'h1C, 0, 0, 0); model_frame(8'h1C, 0, 0);
    vectors++;
    if (data_valid !== 1'b1 || data_out !== q[0] || fifo_count !== 4'(q.size())) begin
      miscompares++;
      $display("FAIL good_frame: valid=%b data=%h count=%0d expected data=%h count=%0d", data_valid, data_out, fifo_count, q[0], q.size());
    end
    vectors++;
    if (n_perr !== e_perr || n_ferr !== e_ferr || n_ovf !== e_ovf || n_tout !== e_tout) begin
      miscompares++;
      $display("FAIL good_frame_pulses: perr=%0d ferr=%0d ovf=%0d tout=%0d", n_perr, n_ferr, n_ovf, n_tout);
    end
    data_ready = 1'b1; @(negedge clk); data_ready = 1'b0; void'(q.pop_front());
    vectors++;
    if (data_valid !== 1'b0 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL good_frame_pop: valid=%b count=%0d expected 0 0", data_valid, fifo_count);
    end
  endtask

  task automatic test_errors;
    send_frame(8'h1C, 1, 0, 0); model_frame(8'h1C, 1, 0);
    vectors++;
    if (n_perr !== e_perr || n_ferr !== e_ferr || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL parity_error: perr=%0d (exp %0d) ferr=%0d count=%0d", n_perr, e_perr, n_ferr, fifo_count);
    end
    send_frame(8'hF0, 0, 1, 0); model_frame(8'hF0, 0, 1);
    vectors++;
    if (n_ferr !== e_ferr || n_perr !== e_perr || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL frame_error: ferr=%0d (exp %0d) perr=%0d count=%0d", n_ferr, e_ferr, n_perr, fifo_count);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] d;
    d = 8'h6B;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(d[i], 0);
    rx = 1'b1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_busy_mid: busy=%b expected 1", busy);
    end
    repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
    e_tout++;
    vectors++;
    if (n_tout !== e_tout || busy !== 1'b0 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL timeout: tout=%0d (exp %0d) busy=%b count=%0d", n_tout, e_tout, busy, fifo_count);
    end
    send_frame(8'h5A, 0, 0, 0); model_frame(8'h5A, 0, 0);
    vectors++;
    if (data_valid !== 1'b1 || data_out !== 8'h5A || n_perr !== e_perr || n_ferr !== e_ferr) begin
      miscompares++;
      $display("FAIL after_timeout: valid=%b data=%h expected 5a", data_valid, data_out);
    end
    data_ready = 1'b1; @(negedge clk); data_ready = 1'b0; void'(q.pop_front());
  endtask

  task automatic test_overflow;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= 9; i++) begin
        if (pass == 1 && i == 9) begin
          send_frame(8'(i), 0, 0, 1);
          void'(q.pop_front());
          q.push_back(8'(i));
        end else begin
          send_frame(8'(i), 0, 0, 0); model_frame(8'(i), 0, 0);
        end
      end
      vectors++;
      if (fifo_count !== 4'(q.size()) || n_ovf !== e_ovf) begin
        miscompares++;
        $display("FAIL overflow_pass%0d: count=%0d (exp %0d) ovf=%0d (exp %0d)", pass, fifo_count, q.size(), n_ovf, e_ovf);
      end
      data_ready = 1'b1;
      while (q.size() > 0) begin
        vectors++;
        if (data_valid !== 1'b1 || data_out !== q[0]) begin
          miscompares++;
          $display("FAIL overflow_drain%0d: valid=%b data=%h expected %h", pass, data_valid, data_out, q[0]);
        end
        @(negedge clk); void'(q.pop_front());
      end
      data_ready = 1'b0;
      vectors++;
      if (data_valid !== 1'b0 || fifo_count !== 4'd0) begin
        miscompares++;
        $display("FAIL overflow_empty%0d: valid=%b count=%0d", pass, data_valid, fifo_count);
      end
    end
  endtask

  task automatic test_glitch;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx_clk = 1'b0; @(negedge clk); rx_clk = 1'b1;
    repeat (10) @(negedge clk);
    rx_clk = 1'b0; repeat (FILTER_LEN - 1) @(negedge clk); rx_clk = 1'b1;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy_seen !== 1'b0 || n_perr !== e_perr || n_ferr !== e_ferr || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL glitch: busy_seen=%b perr=%0d ferr=%0d count=%0d", busy_seen, n_perr, n_ferr, fifo_count);
    end
    send_frame(8'h3C, 0, 0, 0); model_frame(8'h3C, 0, 0);
    vectors++;
    if (data_out !== 8'h3C || fifo_count !== 4'd1) begin
      miscompares++;
      $display("FAIL glitch_followup: data=%h count=%0d expected 3c 1", data_out, fifo_count);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'h96;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(d[i], 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hAA, 0, 0, 0); model_frame(8'hAA, 0, 0);
    vectors++;
    if (data_valid !== 1'b1 || data_out !== 8'hAA || fifo_count !== 4'd1 || n_perr !== e_perr || n_ferr !== e_ferr) begin
      miscompares++;
      $display("FAIL reset_mid_frame: valid=%b data=%h count=%0d expected aa 1", data_valid, data_out, fifo_count);
    end
    data_ready = 1'b1; @(negedge clk); data_ready = 1'b0; void'(q.pop_front());
  endtask

  task automatic test_random;
    logic [7:0] d;
    int kind, k;
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      kind = $urandom_range(0, 5);
      send_frame(d, kind == 0, kind == 1, 0);
      model_frame(d, kind == 0, kind == 1);
      vectors++;
      if (n_perr !== e_perr || n_ferr !== e_ferr || n_ovf !== e_ovf || fifo_count !== 4'(q.size())) begin
        miscompares++;
        $display("FAIL random_frame%0d: perr=%0d/%0d ferr=%0d/%0d ovf=%0d/%0d count=%0d/%0d", n, n_perr, e_perr, n_ferr, e_ferr, n_ovf, e_ovf, fifo_count, q.size());
      end
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, q.size());
        data_ready = 1'b1;
        for (int j = 0; j < k; j++) begin
          vectors++;
          if (data_valid !== 1'b1 || data_out !== q[0]) begin
            miscompares++;
            $display("FAIL random_drain%0d: valid=%b data=%h expected %h", n, data_valid, data_out, q[0]);
          end
          @(negedge clk); void'(q.pop_front());
        end
        data_ready = 1'b0;
      end
    end
    data_ready = 1'b1;
    while (q.size() > 0) begin
      vectors++;
      if (data_valid !== 1'b1 || data_out !== q[0]) begin
        miscompares++;
        $display("FAIL random_final: valid=%b data=%h expected %h", data_valid, data_out, q[0]);
      end
      @(negedge clk); void'(q.pop_front());
    end
    data_ready = 1'b0;
    vectors++;
    if (data_valid !== 1'b0 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL random_empty: valid=%b count=%0d", data_valid, fifo_count);
    end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_clk = 1'b1; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_good_frame;
    test_errors;
    test_timeout;
    test_overflow;
    test_glitch;
    test_reset_mid_frame;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
